// File: rtl/eth_arb_pkg.sv
// rtl/eth_arb_pkg.sv - shared types and constants for the two-port Ethernet TX frame arbiter
package eth_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    DROP = 2'd2
  } arb_state_e;

  localparam int MAX_LEN_DEFAULT = 1518;

endpackage

// File: rtl/eth_arb_rr_pick.sv
// rtl/eth_arb_rr_pick.sv - two-request one-hot picker, round-robin or fixed priority to port 0
module eth_arb_rr_pick
  import eth_arb_pkg::*;
#(
  parameter bit ROUND_ROBIN = 1'b1
) (
  input  logic [1:0] i_req,
  input  logic       i_last,
  output logic [1:0] o_gnt
);

  // i_last is the index of the port that owned the previous frame
  always_comb begin
    o_gnt = i_req;
    if (i_req == 2'b11) begin
      o_gnt = (ROUND_ROBIN && !i_last) ? 2'b10 : 2'b01;
    end
  end

endmodule

// File: rtl/eth_tx_frame_arb.sv
// rtl/eth_tx_frame_arb.sv - frame-granular two-port AXI-Stream arbiter with length truncation
module eth_tx_frame_arb
  import eth_arb_pkg::*;
#(
  parameter int MAX_LEN     = MAX_LEN_DEFAULT,
  parameter bit ROUND_ROBIN = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] s0_axis_tdata,
  input  logic       s0_axis_tvalid,
  output logic       s0_axis_tready,
  input  logic       s0_axis_tlast,
  input  logic       s0_axis_tuser,
  input  logic [7:0] s1_axis_tdata,
  input  logic       s1_axis_tvalid,
  output logic       s1_axis_tready,
  input  logic       s1_axis_tlast,
  input  logic       s1_axis_tuser,
  output logic [7:0] m_axis_tdata,
  output logic       m_axis_tvalid,
  input  logic       m_axis_tready,
  output logic       m_axis_tlast,
  output logic       m_axis_tuser,
  output logic [1:0] grant,
  output logic       trunc_pulse
);

  localparam int CW = $clog2(MAX_LEN + 1);
  localparam logic [CW-1:0] LAST_BEAT = CW'(MAX_LEN - 1);

  arb_state_e    r_state, w_state_nxt;
  logic [1:0]    r_grant;
  logic [1:0]    w_pick;
  logic [CW-1:0] r_cnt;
  logic          r_last;
  logic          r_trunc;

  logic       w_sel;
  logic [7:0] w_src_tdata;
  logic       w_src_tvalid, w_src_tlast, w_src_tuser;
  logic       w_src_ready, w_force, w_m_hs, w_any_req;

  eth_arb_rr_pick #(.ROUND_ROBIN(ROUND_ROBIN)) u_pick (
    .i_req  ({s1_axis_tvalid, s0_axis_tvalid}),
    .i_last (r_last),
    .o_gnt  (w_pick)
  );

  assign w_sel        = r_grant[1];
  assign w_src_tdata  = w_sel ? s1_axis_tdata  : s0_axis_tdata;
  assign w_src_tvalid = w_sel ? s1_axis_tvalid : s0_axis_tvalid;
  assign w_src_tlast  = w_sel ? s1_axis_tlast  : s0_axis_tlast;
  assign w_src_tuser  = w_sel ? s1_axis_tuser  : s0_axis_tuser;
  assign w_any_req    = s0_axis_tvalid | s1_axis_tvalid;

  // Final allowed beat of an over-long frame is closed and marked bad for the MAC
  assign w_force = (r_cnt == LAST_BEAT) && !w_src_tlast;
  assign w_m_hs  = w_src_tvalid && m_axis_tready;

  assign m_axis_tdata   = w_src_tdata;
  assign s0_axis_tready = w_src_ready && r_grant[0];
  assign s1_axis_tready = w_src_ready && r_grant[1];
  assign grant          = r_grant;
  assign trunc_pulse    = r_trunc;

  always_comb begin
    w_state_nxt   = r_state;
    m_axis_tvalid = 1'b0;
    m_axis_tlast  = 1'b0;
    m_axis_tuser  = 1'b0;
    w_src_ready   = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_any_req) w_state_nxt = SEND;
      end
      SEND: begin
        m_axis_tvalid = w_src_tvalid;
        m_axis_tlast  = w_src_tlast | w_force;
        m_axis_tuser  = w_src_tuser | w_force;
        w_src_ready   = m_axis_tready;
        if (w_m_hs) begin
          if (w_src_tlast)  w_state_nxt = IDLE;
          else if (w_force) w_state_nxt = DROP;
        end
      end
      DROP: begin
        w_src_ready = 1'b1;
        if (w_src_tvalid && w_src_tlast) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_grant <= 2'b00;
      r_cnt   <= '0;
      r_last  <= 1'b1;
      r_trunc <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_trunc <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_any_req) begin
            r_grant <= w_pick;
            r_cnt   <= '0;
          end
        end
        SEND: begin
          if (w_m_hs) begin
            r_cnt <= r_cnt + CW'(1);
            if (w_src_tlast) begin
              r_grant <= 2'b00;
              r_last  <= w_sel;
            end else if (w_force) begin
              r_trunc <= 1'b1;
            end
          end
        end
        DROP: begin
          if (w_src_tvalid && w_src_tlast) begin
            r_grant <= 2'b00;
            r_last  <= w_sel;
          end
        end
        default: r_grant <= 2'b00;
      endcase
    end
  end

endmodule

// File: tb/tb_eth_tx_frame_arb.sv
// tb/tb_eth_tx_frame_arb.sv - randomized frame-level bench for eth_tx_frame_arb against a behavioural model
module tb_eth_tx_frame_arb;

  typedef struct packed {
    logic [7:0] data;
    logic       last;
    logic       user;
  } beat_t;

  localparam int ML [2] = '{64, 1518};
  localparam bit RR [2] = '{1'b1, 1'b0};

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic [7:0] s_tdata  [2][2];
  logic       s_tvalid [2][2];
  logic       s_tlast  [2][2];
  logic       s_tuser  [2][2];
  logic       m_tready [2];
  wire  [7:0] m_tdata  [2];
  wire        m_tvalid [2];
  wire        m_tlast  [2];
  wire        m_tuser  [2];
  wire        s0_rdy   [2];
  wire        s1_rdy   [2];
  wire        trunc    [2];
  wire  [1:0] grant    [2];

  for (genvar g = 0; g < 2; g++) begin : g_dut
    eth_tx_frame_arb #(.MAX_LEN(g == 0 ? 64 : 1518), .ROUND_ROBIN(g == 0 ? 1'b1 : 1'b0)) u_dut (
      .clk(clk), .rst(rst),
      .s0_axis_tdata(s_tdata[g][0]), .s0_axis_tvalid(s_tvalid[g][0]), .s0_axis_tready(s0_rdy[g]),
      .s0_axis_tlast(s_tlast[g][0]), .s0_axis_tuser(s_tuser[g][0]),
      .s1_axis_tdata(s_tdata[g][1]), .s1_axis_tvalid(s_tvalid[g][1]), .s1_axis_tready(s1_rdy[g]),
      .s1_axis_tlast(s_tlast[g][1]), .s1_axis_tuser(s_tuser[g][1]),
      .m_axis_tdata(m_tdata[g]), .m_axis_tvalid(m_tvalid[g]), .m_axis_tready(m_tready[g]),
      .m_axis_tlast(m_tlast[g]), .m_axis_tuser(m_tuser[g]),
      .grant(grant[g]), .trunc_pulse(trunc[g])
    );
  end

  int    n_vec = 0;
  int    n_err = 0;
  beat_t srcq [2][2][$];
  beat_t mout [2][$];
  int    owners [2][$];
  beat_t ref_frame [$];
  int    mo_own [2], mo_cnt [2], mo_last [2];
  bit    mo_drop [2], mo_trunc [2];
  bit    hs [2][2];
  bit    pstall [2];
  logic [10:0] pout [2];
  int    trunc_cnt [2], drop_cnt [2];
  int    vprob = 100;
  int    rprob = 100;

  task automatic chk(input string nm, input int d, input longint act, input longint exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s dut%0d: got %0d expected %0d", nm, d, act, exp);
    end
  endtask

  function automatic logic rdy(input int d, input int p);
    return (p == 1) ? s1_rdy[d] : s0_rdy[d];
  endfunction

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      mo_own[d] = -1; mo_cnt[d] = 0; mo_last[d] = 1;
      mo_drop[d] = 1'b0; mo_trunc[d] = 1'b0; pstall[d] = 1'b0;
    end
  endtask

  task automatic clear_mon();
    for (int d = 0; d < 2; d++) begin
      mout[d].delete(); owners[d].delete();
      trunc_cnt[d] = 0; drop_cnt[d] = 0;
    end
    ref_frame.delete();
  endtask

  // Frame-level expectation: who owns the bus, how many beats it has sent, whether it is being discarded
  task automatic check_cycle(input int d);
    int o, pick;
    logic ev, el, eu, er0, er1, frc;
    logic [1:0] eg;
    o = mo_own[d];
    ev = 0; el = 0; eu = 0; er0 = 0; er1 = 0; eg = 2'b00; frc = 0;
    if (o >= 0) begin
      eg = (o == 1) ? 2'b10 : 2'b01;
      if (!mo_drop[d]) begin
        frc = (mo_cnt[d] == ML[d] - 1) && !s_tlast[d][o];
        ev = s_tvalid[d][o];
        el = s_tlast[d][o] | frc;
        eu = s_tuser[d][o] | frc;
        if (o == 0) er0 = m_tready[d]; else er1 = m_tready[d];
      end else begin
        if (o == 0) er0 = 1'b1; else er1 = 1'b1;
      end
    end
    chk("grant", d, grant[d], eg);
    chk("m_tvalid", d, m_tvalid[d], ev);
    chk("s0_tready", d, s0_rdy[d], er0);
    chk("s1_tready", d, s1_rdy[d], er1);
    chk("trunc_pulse", d, trunc[d], mo_trunc[d]);
    if (ev) begin
      chk("m_tdata", d, m_tdata[d], s_tdata[d][o]);
      chk("m_tlast", d, m_tlast[d], el);
      chk("m_tuser", d, m_tuser[d], eu);
    end
    if (pstall[d]) chk("stall_hold", d, {m_tvalid[d], m_tdata[d], m_tlast[d], m_tuser[d]}, pout[d]);
    pstall[d] = m_tvalid[d] && !m_tready[d];
    pout[d] = {m_tvalid[d], m_tdata[d], m_tlast[d], m_tuser[d]};

    for (int p = 0; p < 2; p++) hs[d][p] = s_tvalid[d][p] && rdy(d, p);
    if (m_tvalid[d] && m_tready[d]) begin
      mout[d].push_back({m_tdata[d], m_tlast[d], m_tuser[d]});
      if (m_tlast[d]) owners[d].push_back(grant[d] == 2'b10 ? 1 : 0);
    end
    if (trunc[d]) trunc_cnt[d]++;
    if (!m_tvalid[d] && (hs[d][0] || hs[d][1])) drop_cnt[d]++;

    mo_trunc[d] = 1'b0;
    if (o < 0) begin
      if (s_tvalid[d][0] || s_tvalid[d][1]) begin
        if (s_tvalid[d][0] && s_tvalid[d][1]) pick = RR[d] ? 1 - mo_last[d] : 0;
        else pick = s_tvalid[d][1] ? 1 : 0;
        mo_own[d] = pick; mo_cnt[d] = 0; mo_drop[d] = 1'b0;
      end
    end else if (!mo_drop[d]) begin
      if (s_tvalid[d][o] && m_tready[d]) begin
        if (s_tlast[d][o]) begin
          mo_last[d] = o; mo_own[d] = -1;
        end else if (mo_cnt[d] == ML[d] - 1) begin
          mo_drop[d] = 1'b1; mo_trunc[d] = 1'b1;
        end
        mo_cnt[d]++;
      end
    end else if (s_tvalid[d][o] && s_tlast[d][o]) begin
      mo_last[d] = o; mo_own[d] = -1;
    end
  endtask

  task automatic drive_update();
    beat_t b;
    for (int d = 0; d < 2; d++) begin
      for (int p = 0; p < 2; p++) begin
        if (hs[d][p]) void'(srcq[d][p].pop_front());
        if (!(s_tvalid[d][p] && !hs[d][p])) begin
          if (srcq[d][p].size() > 0 && int'($urandom_range(99)) < vprob) begin
            b = srcq[d][p][0];
            s_tvalid[d][p] = 1'b1; s_tdata[d][p] = b.data;
            s_tlast[d][p] = b.last; s_tuser[d][p] = b.user;
          end else begin
            s_tvalid[d][p] = 1'b0; s_tdata[d][p] = 8'($urandom);
            s_tlast[d][p] = 1'b0; s_tuser[d][p] = 1'b0;
          end
        end
        hs[d][p] = 1'b0;
      end
      m_tready[d] = int'($urandom_range(99)) < rprob;
    end
  endtask

  task automatic step();
    @(negedge clk);
    for (int d = 0; d < 2; d++) check_cycle(d);
    @(posedge clk);
    #1;
    drive_update();
  endtask

  function automatic bit all_idle();
    for (int d = 0; d < 2; d++) begin
      if (mo_own[d] != -1) return 1'b0;
      for (int p = 0; p < 2; p++)
        if (srcq[d][p].size() != 0 || s_tvalid[d][p]) return 1'b0;
    end
    return 1'b1;
  endfunction

  task automatic run(input int maxc);
    int c;
    c = 0;
    while (!all_idle() && c < maxc) begin
      step();
      c++;
    end
    chk("phase_done", 0, all_idle(), 1);
    step();
    step();
  endtask

  task automatic push_frame(input int p, input int len, input bit usr);
    beat_t b;
    for (int i = 0; i < len; i++) begin
      b.data = 8'($urandom);
      b.last = (i == len - 1);
      b.user = usr;
      srcq[0][p].push_back(b);
      srcq[1][p].push_back(b);
      ref_frame.push_back(b);
    end
  endtask

  task automatic drop_sources();
    for (int d = 0; d < 2; d++)
      for (int p = 0; p < 2; p++) begin
        srcq[d][p].delete();
        s_tvalid[d][p] = 1'b0; s_tlast[d][p] = 1'b0; s_tuser[d][p] = 1'b0;
        hs[d][p] = 1'b0;
      end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    for (int d = 0; d < 2; d++) begin
      chk("rst_grant", d, grant[d], 0);
      chk("rst_m_tvalid", d, m_tvalid[d], 0);
      chk("rst_s0_tready", d, s0_rdy[d], 0);
      chk("rst_s1_tready", d, s1_rdy[d], 0);
      chk("rst_trunc", d, trunc[d], 0);
    end
    drop_sources();
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  int errs;
  int c6;

  initial begin
    for (int d = 0; d < 2; d++) begin
      m_tready[d] = 1'b1;
      for (int p = 0; p < 2; p++) begin
        s_tdata[d][p] = 8'h00; s_tvalid[d][p] = 1'b0;
        s_tlast[d][p] = 1'b0; s_tuser[d][p] = 1'b0; hs[d][p] = 1'b0;
      end
    end
    model_reset();
    #2;
    do_reset();

    // single 64-byte frame on port 0 (exactly MAX_LEN for dut0)
    clear_mon();
    push_frame(0, 64, 1'b0);
    run(500);
    for (int d = 0; d < 2; d++) begin
      chk("p1_beats", d, mout[d].size(), 64);
      if (mout[d].size() == 64) begin
        chk("p1_tlast_beat64", d, mout[d][63].last, 1);
        chk("p1_tuser_beat64", d, mout[d][63].user, 0);
        chk("p1_tlast_beat63", d, mout[d][62].last, 0);
      end
      chk("p1_frames", d, owners[d].size(), 1);
      if (owners[d].size() == 1) chk("p1_owner", d, owners[d][0], 0);
      chk("p1_trunc", d, trunc_cnt[d], 0);
    end

    // both ports continuously valid, three frames each
    do_reset();
    clear_mon();
    for (int f = 0; f < 3; f++) begin
      push_frame(0, 8 + 4 * f, 1'b0);
      push_frame(1, 5 + 3 * f, 1'b1);
    end
    run(1000);
    for (int d = 0; d < 2; d++) begin
      chk("p2_frames", d, owners[d].size(), 6);
      if (owners[d].size() == 6)
        for (int i = 0; i < 6; i++)
          chk($sformatf("p2_order%0d", i), d, owners[d][i], (d == 0) ? (i % 2) : (i / 3));
    end

    // 100-beat frame on port 1: truncated at 64 by dut0, forwarded whole by dut1
    clear_mon();
    push_frame(1, 100, 1'b0);
    run(1000);
    chk("p3_beats", 0, mout[0].size(), 64);
    chk("p3_beats", 1, mout[1].size(), 100);
    if (mout[0].size() == 64) begin
      chk("p3_forced_tlast", 0, mout[0][63].last, 1);
      chk("p3_forced_tuser", 0, mout[0][63].user, 1);
    end
    if (mout[1].size() == 100) chk("p3_tuser_pass", 1, mout[1][99].user, 0);
    chk("p3_trunc", 0, trunc_cnt[0], 1);
    chk("p3_trunc", 1, trunc_cnt[1], 0);
    chk("p3_dropped", 0, drop_cnt[0], 36);

    // 200-byte frame with a 50% ready sink
    clear_mon();
    rprob = 50;
    push_frame(0, 200, 1'b0);
    run(3000);
    chk("p4_beats", 1, mout[1].size(), 200);
    chk("p4_beats", 0, mout[0].size(), 64);
    for (int d = 0; d < 2; d++) begin
      errs = 0;
      for (int i = 0; i < mout[d].size() && i < ref_frame.size(); i++)
        if (mout[d][i].data != ref_frame[i].data) errs++;
      chk("p4_seq_errs", d, errs, 0);
    end

    // random traffic on both ports
    clear_mon();
    rprob = 70;
    vprob = 60;
    for (int f = 0; f < 20; f++) begin
      push_frame(0, $urandom_range(150, 1), 1'($urandom_range(1)));
      push_frame(1, $urandom_range(150, 1), 1'($urandom_range(1)));
    end
    run(40000);
    for (int d = 0; d < 2; d++) chk("p5_frames", d, owners[d].size(), 40);

    // reset in the middle of a frame while beat 30 is on the bus
    do_reset();
    clear_mon();
    rprob = 100;
    vprob = 100;
    push_frame(0, 100, 1'b0);
    c6 = 0;
    while (mout[1].size() < 29 && c6 < 300) begin
      step();
      c6++;
    end
    chk("p6_reach_beat30", 1, mout[1].size(), 29);
    #1;
    for (int d = 0; d < 2; d++) chk("p6_busy", d, m_tvalid[d], 1);
    do_reset();
    clear_mon();
    push_frame(1, 5, 1'b0);
    push_frame(0, 5, 1'b0);
    run(200);
    for (int d = 0; d < 2; d++) begin
      chk("p6_frames", d, owners[d].size(), 2);
      if (owners[d].size() == 2) begin
        chk("p6_first_owner", d, owners[d][0], 0);
        chk("p6_second_owner", d, owners[d][1], 1);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/eth_tx_frame_arb.md
ETH_TX_FRAME_ARB -- requirements
Module: eth_tx_frame_arb

Interface
REQ-001 Parameter MAX_LEN, default 1518, max beats per forwarded frame (range 64..16383).
REQ-002 Parameter ROUND_ROBIN, default 1; 1 = round-robin, 0 = fixed priority to port 0.
REQ-003 clk  input  1  single clock for all logic.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 sN_axis_tdata (N=0,1)  input  8  requester N byte.
REQ-006 sN_axis_tvalid  input  1  requester N beat valid.
REQ-007 sN_axis_tready  output  1  requester N beat accepted.
REQ-008 sN_axis_tlast  input  1  requester N last beat of frame.
REQ-009 sN_axis_tuser  input  1  requester N bad-frame flag.
REQ-010 m_axis_tdata  output  8  to MAC tx_axis_tdata.
REQ-011 m_axis_tvalid  output  1  to MAC tx_axis_tvalid.
REQ-012 m_axis_tready  input  1  from MAC tx_axis_tready.
REQ-013 m_axis_tlast  output  1  to MAC tx_axis_tlast.
REQ-014 m_axis_tuser  output  1  to MAC tx_axis_tuser (1 = MAC drops frame).
REQ-015 grant  output  2  one-hot owner of current frame, 0 when idle.
REQ-016 trunc_pulse  output  1  one-cycle pulse when a frame is truncated.

Function
REQ-017 States IDLE, SEND, DROP; all requester interleaving is frame-granular, never beat-granular.
REQ-018 IDLE: m_axis_tvalid=0, both sN_axis_tready=0, grant=0.
REQ-019 IDLE with any sN_axis_tvalid=1: grant registered, state -> SEND next cycle; first beat may transfer on the cycle after the decision (1-cycle arbitration latency).
REQ-020 Both valid, ROUND_ROBIN=1: grant the port not granted last; last-grant pointer resets to port 1, so port 0 wins first.
REQ-021 Both valid, ROUND_ROBIN=0: port 0 always wins.
REQ-022 SEND: m_axis_tdata/tvalid/tlast/tuser combinationally follow granted port; granted sN_axis_tready = m_axis_tready; non-granted tready=0.
REQ-023 Beat counter, width $clog2(MAX_LEN+1), cleared on IDLE->SEND, incremented per m handshake.
REQ-024 SEND, handshake with tlast=1 (source or forced): state -> IDLE, last-grant pointer updated to current owner.
REQ-025 SEND, counter=MAX_LEN-1 and source tlast=0: m_axis_tlast and m_axis_tuser forced to 1 on that beat; on its handshake trunc_pulse=1 for one cycle, state -> DROP.
REQ-026 Frame of exactly MAX_LEN beats ending with source tlast: forwarded unmodified, no trunc_pulse.
REQ-027 DROP: m_axis_tvalid=0; granted sN_axis_tready=1; beats discarded until source tlast handshake, then IDLE with pointer updated.
REQ-028 m_axis_tvalid may not deassert mid-beat; a stalled beat (m_axis_tready=0) holds all m outputs stable because the source holds per AXI-Stream rules.
REQ-029 Source tuser passes through unchanged except when forced by REQ-025.
REQ-030 No combinational path from m_axis_tready to m_axis_tvalid.

Reset
REQ-031 rst asserts asynchronously: state IDLE, grant=0, counter=0, pointer=port 1, trunc_pulse=0, all tready=0, m_axis_tvalid=0.
REQ-032 Reset mid-frame abandons the frame without generating tlast; downstream MAC FIFO reset clears it.

Structure
REQ-033 Shared package eth_arb_pkg holds state enum (IDLE/SEND/DROP) and MAX_LEN default constant.
REQ-034 One sub-module eth_arb_rr_pick: 2-request, pointer-in, one-hot grant-out combinational picker; everything else in eth_tx_frame_arb.

Verification
REQ-035 Port 0 sends 64-byte frame, port 1 idle, m_axis_tready=1 -> 64 beats on m, tlast on beat 64, grant=01, back to IDLE.
REQ-036 Both ports continuously valid, ROUND_ROBIN=1, 3 frames each -> grant order 0,1,0,1,0,1, no interleaved beats.
REQ-037 Same stimulus, ROUND_ROBIN=0 -> port 0 frames all forwarded first, port 1 starved until port 0 tvalid=0.
REQ-038 MAX_LEN=64, port 1 sends 100 beats -> 64 beats on m, beat 64 tlast=1 tuser=1, trunc_pulse once, remaining 36 beats consumed with m_axis_tvalid=0.
REQ-039 m_axis_tready toggled randomly 50% during 200-byte frame -> byte sequence on m identical to source, outputs stable while stalled.
REQ-040 rst asserted at beat 30 of a frame -> m_axis_tvalid and tready drop same cycle, grant=0; after release next frame starts cleanly with port 0.
